btf_dit_ct: RTL and testbench
=============================

Name: btf_dit_ct

Overview:
- Pipelined Cooley-Tukey decimation-in-time butterfly.
- Computes out_a = a + b·w mod q and out_b = a − b·w mod q.
- It is the DIT counterpart of the Gentleman-Sande DIF butterfly: multiply first, then add/sub.
- Used in SDF NTT stages that consume bit-reversed input and produce natural order. Carries a valid/intt tag pipeline so the enclosing stage controller needs no separate delay line.

Parameters:
- LOGQ, 64, coefficient/modulus width.
- IS_Q_FIXED, 0, 1 = use constant Q and ignore port q.
- Q, 0, fixed modulus when IS_Q_FIXED=1.
- DELAY_ADD, 1, modadd latency in cycles.
- DELAY_SUB, 1, modsub latency in cycles.
- DELAY_MUL, 6, integer multiply latency inside modmul.
- DELAY_RED, 4, reduction latency inside modmul.
- DELAY_DIV2, 1, latency of the optional halving stage.
- LOGN/DSP_W/DSP_H/TYPE_RED/W/L/MULLAT/ADDPIP/DELAY_BRAM/DELAY_BROM/DELAY_FIFO/BTF_GS, 0, passed unchanged to modadd/modsub/modmul.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- intt  in  1  per-sample inverse-transform tag.
- btf_in_a  in  LOGQ  operand a, < q.
- btf_in_b  in  LOGQ  operand b, < q.
- btf_in_w  in  LOGQ  twiddle, < q.
- q  in  LOGQ  modulus; must be stable while busy=1.
- out_valid  out  1  result valid.
- out_intt  out  1  intt tag aligned with the result.
- btf_out_a  out  LOGQ  (a + bw) mod q.
- btf_out_b  out  LOGQ  (a − bw) mod q.
- busy  out  1  any valid sample in flight.

Behaviour:
- Datapath:
  - bw = modmul(b, w, q), latency LM = DELAY_MUL + DELAY_RED.
  - a is delayed LM cycles in a shiftreg so it aligns with bw.
  - modadd(a_d, bw) and modsub(a_d, bw) run in parallel, LAS = max(DELAY_ADD, DELAY_SUB). The shorter of the two results is padded to LAS.
- Total latency LT = LM + LAS, which is 11 at defaults. A sample accepted at edge n appears at edge n+LT.
- Throughput: one sample per cycle, no back-pressure, no bubbles inserted. Idle cycles (in_valid=0) propagate as invalid slots.
- Valid/intt tag pipeline: LT-deep shift register of {valid, intt}, clocked every cycle.
- Outputs:
  - out_valid and out_intt come from the last tag stage.
  - btf_out_a and btf_out_b are ANDed with out_valid, so they read 0 whenever out_valid=0.
- busy = OR of all tag valid bits, registered. It reads 1 on the edge after the first accepted sample and 0 on the edge after the last result leaves.
- Reset:
  - rst=0 asynchronously clears all tag bits, out_valid, out_intt and busy. Data outputs therefore read 0.
  - Datapath registers need no reset.
  - Reset during operation discards every in-flight sample; no partial results emerge after release.
  - The first sample accepted after release appears exactly LT cycles later.
- Arithmetic: inputs are in [0, q) and outputs are in [0, q). Behaviour is undefined for inputs ≥ q; the bench does not check it.
- IS_Q_FIXED=1: the q port is ignored and constant Q is used everywhere.
- Edge cases:
  - b=0 or w=0 gives out_a = out_b = a.
  - bw = a gives out_b = 0.
  - a + bw = q gives out_a = 0.

Optional Feature:
- Macro: BTF_CT_DIV2_EN.
- When defined:
  - A halving stage is appended to both outputs and applies only when the sample's intt tag is 1: x' = x even ? x>>1 : (x+q)>>1. The sum is computed at LOGQ+1 bits.
  - When intt=0 the value passes through, but still takes the same DELAY_DIV2 cycles.
  - LT becomes LM + LAS + DELAY_DIV2, and the tag pipeline is lengthened to match.
- When undefined: no halving stage; intt is only carried through as out_intt.

Decomposition:
- Shared package/header: the LT and LM localparam formulas, and the tag struct {valid, intt}, width 2.
- Reuses the existing modmul, modadd, modsub and shiftreg blocks.
- One new sub-module, btf_tag_pipe: a parameterised-depth {valid, intt} shift register with async active-low clear that also produces busy.

Test Plan:
- q=17, single sample a=3, b=5, w=2, intt=0 -> out_valid exactly 11 cycles later; out_a=13, out_b=10; out_valid=1 for one cycle only.
- q=17, a=16, b=16, w=16 -> bw=1, out_a=0, out_b=15.
- q=17, b=0 or w=0 with a=9 -> out_a=9, out_b=9.
- Back-to-back stream of 20 random samples with random in_valid gaps, q=0xFFFFFFFF00000001 -> results match a reference model in order. The out_valid pattern equals the in_valid pattern delayed by LT. busy falls 1 cycle after the last out_valid.
- Assert rst=0 mid-stream with 5 samples in flight -> out_valid, busy and outputs go to 0 immediately. No stale result appears after release. A new sample a=1, b=1, w=1 yields out_a=2, out_b=0 after LT.
- With BTF_CT_DIV2_EN, q=17, a=3, b=5, w=2, intt=1 -> out_a=15, out_b=5, latency 12, out_intt=1. With intt=0 -> 13 and 10, latency 12.

Source files
------------

// File: rtl/btf_dit_ct_pkg.sv
// Shared definitions for the Cooley-Tukey DIT butterfly: the {valid, intt}
// tag type and the latency formulas used by the top and the tag pipeline.
// Optional feature macro: BTF_CT_DIV2_EN (appends a halving stage on intt samples).
package btf_dit_ct_pkg;

  // Per-sample tag carried alongside the datapath.
  typedef struct packed {
    logic valid;
    logic intt;
  } btf_tag_t;

`ifdef BTF_CT_DIV2_EN
  localparam bit DIV2_EN = 1'b1;
`else
  localparam bit DIV2_EN = 1'b0;
`endif

  // Modular multiply latency: integer multiply followed by reduction.
  function automatic int lm_calc(input int delay_mul, input int delay_red);
    return delay_mul + delay_red;
  endfunction

  // Add and subtract run side by side; the shorter one is padded.
  function automatic int las_calc(input int delay_add, input int delay_sub);
    return (delay_add > delay_sub) ? delay_add : delay_sub;
  endfunction

  // End-to-end latency; tail is the optional halving stage (0 when absent).
  function automatic int lt_calc(input int lm, input int las, input int tail);
    return lm + las + tail;
  endfunction

endpackage

// File: rtl/btf_dit_ct_tag_pipe.sv
// Fixed-depth {valid, intt} shift register that travels alongside the
// butterfly datapath. Async active-low clear; also produces a registered
// busy flag that is high while any valid tag is in flight.
module btf_tag_pipe
  import btf_dit_ct_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int TAP   = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  input  btf_tag_t tag_in,
  output btf_tag_t tag_out,
  output logic     tap_intt,
  output logic     busy
);

  btf_tag_t stages [DEPTH];
  logic     any_valid;

  // Shift tags one stage per cycle; reset drops every in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is control state, so every entry is cleared; the
      // wide data arrays in the top are deliberately left without reset.
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  // Reduce the valid bits of every stage.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it a latch would be inferred.
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stages[i].valid;
    end
  end

  // Register busy so it rises one edge after a tag enters and falls one
  // edge after the last tag leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= any_valid;
    end
  end

  assign tag_out  = stages[DEPTH-1];
  assign tap_intt = stages[TAP].intt;

endmodule

// File: rtl/btf_dit_ct.sv
// Pipelined Cooley-Tukey decimation-in-time butterfly:
//   btf_out_a = (a + b*w) mod q,  btf_out_b = (a - b*w) mod q.
// Multiply first, then add/sub in parallel. A {valid, intt} tag pipeline
// runs alongside so the enclosing stage needs no separate delay line.
// Optional feature macro: BTF_CT_DIV2_EN -- when defined, both results of
// intt samples are halved mod q in an extra DELAY_DIV2-cycle stage.
// All DELAY_* parameters must be at least 1.
module btf_dit_ct
  import btf_dit_ct_pkg::*;
#(
  parameter int              LOGQ       = 64,
  parameter int              IS_Q_FIXED = 0,
  parameter logic [LOGQ-1:0] Q          = '0,
  parameter int              DELAY_ADD  = 1,
  parameter int              DELAY_SUB  = 1,
  parameter int              DELAY_MUL  = 6,
  parameter int              DELAY_RED  = 4,
  parameter int              DELAY_DIV2 = 1,
  parameter int              LOGN       = 0,
  parameter int              DSP_W      = 0,
  parameter int              DSP_H      = 0,
  parameter int              TYPE_RED   = 0,
  parameter int              W          = 0,
  parameter int              L          = 0,
  parameter int              MULLAT     = 0,
  parameter int              ADDPIP     = 0,
  parameter int              DELAY_BRAM = 0,
  parameter int              DELAY_BROM = 0,
  parameter int              DELAY_FIFO = 0,
  parameter int              BTF_GS     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            intt,
  input  logic [LOGQ-1:0] btf_in_a,
  input  logic [LOGQ-1:0] btf_in_b,
  input  logic [LOGQ-1:0] btf_in_w,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  output logic            out_intt,
  output logic [LOGQ-1:0] btf_out_a,
  output logic [LOGQ-1:0] btf_out_b,
  output logic            busy
);

  localparam int LM   = lm_calc(DELAY_MUL, DELAY_RED);
  localparam int LAS  = las_calc(DELAY_ADD, DELAY_SUB);
  localparam int LDIV = DIV2_EN ? DELAY_DIV2 : 0;
  localparam int LT   = lt_calc(LM, LAS, LDIV);

  // Tuning knobs of the shared arithmetic library. This datapath is
  // behavioural and does not depend on them; they are kept so the parameter
  // interface matches the other butterflies, and negative values are
  // meaningless, hence the empty guard.
  localparam int LIB_CFG = LOGN + DSP_W + DSP_H + TYPE_RED + W + L + MULLAT
                         + ADDPIP + DELAY_BRAM + DELAY_BROM + DELAY_FIFO + BTF_GS;
  if (LIB_CFG < 0) begin : g_lib_cfg_negative
  end

  // ---------------------------------------------------------------------
  // Modulus selection
  // ---------------------------------------------------------------------
  logic [LOGQ-1:0] q_eff;
  assign q_eff = (IS_Q_FIXED != 0) ? Q : q;

  // ---------------------------------------------------------------------
  // Tag pipeline (valid / intt / busy)
  // ---------------------------------------------------------------------
  btf_tag_t tag_in;
  btf_tag_t tag_out;
  logic     tap_intt;

  assign tag_in.valid = in_valid;
  assign tag_in.intt  = intt;

  btf_tag_pipe #(
    .DEPTH (LT),
    .TAP   (LM + LAS - 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .tap_intt (tap_intt),
    .busy     (busy)
  );

  assign out_valid = tag_out.valid;
  assign out_intt  = tag_out.intt;

  // ---------------------------------------------------------------------
  // Modular multiply: bw = b*w mod q, latency LM
  // ---------------------------------------------------------------------
  logic [2*LOGQ-1:0] prod_in;
  logic [2*LOGQ-1:0] mul_pipe [DELAY_MUL];
  logic [LOGQ-1:0]   red_in;
  logic [LOGQ-1:0]   red_pipe [DELAY_RED];
  logic [LOGQ-1:0]   a_pipe   [LM];
  logic [LOGQ-1:0]   a_d;
  logic [LOGQ-1:0]   bw;

  assign prod_in = {{LOGQ{1'b0}}, btf_in_b} * {{LOGQ{1'b0}}, btf_in_w};

  // Integer product pipeline; payload only, qualified by the tag pipeline.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // stage samples its predecessor's value from before the edge.
    mul_pipe[0] <= prod_in;
    for (int i = 1; i < DELAY_MUL; i++) begin
      mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign red_in = LOGQ'(mul_pipe[DELAY_MUL-1] % {{LOGQ{1'b0}}, q_eff});

  // Reduction pipeline producing bw.
  always_ff @(posedge clk) begin
    red_pipe[0] <= red_in;
    for (int i = 1; i < DELAY_RED; i++) begin
      red_pipe[i] <= red_pipe[i-1];
    end
  end

  assign bw = red_pipe[DELAY_RED-1];

  // Delay a by LM cycles so it meets bw.
  always_ff @(posedge clk) begin
    a_pipe[0] <= btf_in_a;
    for (int i = 1; i < LM; i++) begin
      a_pipe[i] <= a_pipe[i-1];
    end
  end

  assign a_d = a_pipe[LM-1];

  // ---------------------------------------------------------------------
  // Modular add / subtract, both padded to LAS cycles
  // ---------------------------------------------------------------------
  logic [LOGQ:0]   add_sum;
  logic [LOGQ-1:0] add_res;
  logic [LOGQ-1:0] sub_res;
  logic [LOGQ-1:0] add_pipe [LAS];
  logic [LOGQ-1:0] sub_pipe [LAS];

  assign add_sum = {1'b0, a_d} + {1'b0, bw};
  assign add_res = (add_sum >= {1'b0, q_eff}) ? LOGQ'(add_sum - {1'b0, q_eff})
                                              : LOGQ'(add_sum);
  assign sub_res = (a_d >= bw) ? (a_d - bw)
                               : LOGQ'({1'b0, a_d} + {1'b0, q_eff} - {1'b0, bw});

  // Add/sub result pipelines; the shorter unit's padding is folded in so
  // both leave together after LAS cycles.
  always_ff @(posedge clk) begin
    add_pipe[0] <= add_res;
    sub_pipe[0] <= sub_res;
    for (int i = 1; i < LAS; i++) begin
      add_pipe[i] <= add_pipe[i-1];
      sub_pipe[i] <= sub_pipe[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Optional halving stage
  // ---------------------------------------------------------------------
  logic [LOGQ-1:0] res_a;
  logic [LOGQ-1:0] res_b;

`ifdef BTF_CT_DIV2_EN
  logic [LOGQ-1:0] div_a_pipe [DELAY_DIV2];
  logic [LOGQ-1:0] div_b_pipe [DELAY_DIV2];

  // x/2 mod q: odd values borrow q first; the sum needs LOGQ+1 bits.
  function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] x,
                                            input logic [LOGQ-1:0] m);
    logic [LOGQ:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[LOGQ:1];
  endfunction

  // Halve intt samples; forward samples pass through with equal latency.
  always_ff @(posedge clk) begin
    div_a_pipe[0] <= tap_intt ? halve(add_pipe[LAS-1], q_eff) : add_pipe[LAS-1];
    div_b_pipe[0] <= tap_intt ? halve(sub_pipe[LAS-1], q_eff) : sub_pipe[LAS-1];
    for (int i = 1; i < DELAY_DIV2; i++) begin
      div_a_pipe[i] <= div_a_pipe[i-1];
      div_b_pipe[i] <= div_b_pipe[i-1];
    end
  end

  assign res_a = div_a_pipe[DELAY_DIV2-1];
  assign res_b = div_b_pipe[DELAY_DIV2-1];
`else
  // Without the halving stage the mid-pipe intt tap has no consumer.
  logic unused_tap_intt;
  assign unused_tap_intt = tap_intt;

  assign res_a = add_pipe[LAS-1];
  assign res_b = sub_pipe[LAS-1];
`endif

  // Data outputs read zero whenever no valid result is presented.
  assign btf_out_a = res_a & {LOGQ{out_valid}};
  assign btf_out_b = res_b & {LOGQ{out_valid}};

endmodule

// File: tb/tb_btf_dit_ct.sv
// Scoreboard bench for btf_dit_ct: a driver pushes expected results with
// their due cycle; an independent monitor pops and compares on out_valid.
module tb_btf_dit_ct;

  localparam int LOGQ = 64;
`ifdef BTF_CT_DIV2_EN
  localparam int LT = 12;
`else
  localparam int LT = 11;
`endif
  localparam logic [63:0] Q_BIG = 64'hFFFFFFFF00000001;

  typedef struct {
    logic [63:0] ea;
    logic [63:0] eb;
    logic        intt;
    int          due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            intt = 1'b0;
  logic [LOGQ-1:0] btf_in_a = '0;
  logic [LOGQ-1:0] btf_in_b = '0;
  logic [LOGQ-1:0] btf_in_w = '0;
  logic [LOGQ-1:0] q = 64'd17;
  logic            out_valid;
  logic            out_intt;
  logic [LOGQ-1:0] btf_out_a;
  logic [LOGQ-1:0] btf_out_b;
  logic            busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb [$];

  btf_dit_ct #(
    .LOGQ (LOGQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .intt      (intt),
    .btf_in_a  (btf_in_a),
    .btf_in_b  (btf_in_b),
    .btf_in_w  (btf_in_w),
    .q         (q),
    .out_valid (out_valid),
    .out_intt  (out_intt),
    .btf_out_a (btf_out_a),
    .btf_out_b (btf_out_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] w, input logic [63:0] m,
                                input logic in_intt,
                                output logic [63:0] ea, output logic [63:0] eb);
    logic [127:0] p;
    logic [64:0]  bw, s, d;
    p  = {64'd0, b} * {64'd0, w};
    bw = 65'(p % {64'd0, m});
    s  = ({1'b0, a} + bw) % {1'b0, m};
    d  = ({1'b0, a} + {1'b0, m} - bw) % {1'b0, m};
`ifdef BTF_CT_DIV2_EN
    if (in_intt) begin
      s = s[0] ? ((s + {1'b0, m}) >> 1) : (s >> 1);
      d = d[0] ? ((d + {1'b0, m}) >> 1) : (d >> 1);
    end
`else
    if (in_intt) begin
      s = s;
    end
`endif
    ea = s[63:0];
    eb = d[63:0];
  endfunction

  // Present one sample this cycle and record what must come out LT later.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] w,
                       input logic t, input logic [63:0] ea, input logic [63:0] eb);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    intt     = t;
    btf_in_a = a;
    btf_in_b = b;
    btf_in_w = w;
    e.ea   = ea;
    e.eb   = eb;
    e.intt = t;
    e.due  = cyc + LT;
    sb.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    intt     = 1'b0;
  endtask

  // Wait for all results, then check busy falls one cycle after the last one.
  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (sb.size() == 0 && !out_valid) break;
    end
    check({tag, "_drain_pending"}, 64'(sb.size()), 64'd0);
    check({tag, "_busy_tail"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_a", btf_out_a, e.ea);
            check("out_b", btf_out_b, e.eb);
            check("out_intt", 64'(out_intt), 64'(e.intt));
            check("latency_cycle", 64'(cyc), 64'(e.due));
          end
        end else begin
          check("idle_out_a_zero", btf_out_a, 64'd0);
          check("idle_out_b_zero", btf_out_b, 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra, rb, rw, ea, eb;
    logic        rt;

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_intt", 64'(out_intt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_a", btf_out_a, 64'd0);
    check("rst_out_b", btf_out_b, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single sample and busy rise timing
    issue(64'd3, 64'd5, 64'd2, 1'b0, 64'd13, 64'd10);
    idle_cycle();
    check("busy_not_yet", 64'(busy), 64'd0);
    @(negedge clk);
    check("busy_rise", 64'(busy), 64'd1);
    drain("single");

    // Boundary vectors: a+bw=q, b=0, w=0
    issue(64'd16, 64'd16, 64'd16, 1'b0, 64'd0, 64'd15);
    issue(64'd9, 64'd0, 64'd7, 1'b0, 64'd9, 64'd9);
    issue(64'd9, 64'd4, 64'd0, 1'b0, 64'd9, 64'd9);
    drain("edges");

    // Random stream with gaps, large prime modulus
    @(negedge clk);
    q = Q_BIG;
    for (int i = 0; i < 20; i++) begin
      while ($urandom_range(0, 2) == 0) idle_cycle();
      ra = {$urandom, $urandom} % Q_BIG;
      rb = {$urandom, $urandom} % Q_BIG;
      rw = {$urandom, $urandom} % Q_BIG;
      rt = 1'($urandom_range(0, 1));
      model(ra, rb, rw, Q_BIG, rt, ea, eb);
      issue(ra, rb, rw, rt, ea, eb);
    end
    drain("stream");

    // Reset mid-stream with 5 samples in flight
    @(negedge clk);
    q = 64'd17;
    for (int i = 0; i < 5; i++) begin
      issue(64'(i + 2), 64'd3, 64'd4, 1'b0, 64'd0, 64'd0);
    end
    idle_cycle();
    check("busy_before_reset", 64'(busy), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_a", btf_out_a, 64'd0);
    check("midrst_out_b", btf_out_b, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * LT) idle_cycle();
    issue(64'd1, 64'd1, 64'd1, 1'b0, 64'd2, 64'd0);
    drain("post_reset");

    // intt tag: halved under the optional stage, pass-through otherwise
`ifdef BTF_CT_DIV2_EN
    issue(64'd3, 64'd5, 64'd2, 1'b1, 64'd15, 64'd5);
`else
    issue(64'd3, 64'd5, 64'd2, 1'b1, 64'd13, 64'd10);
`endif
    issue(64'd3, 64'd5, 64'd2, 1'b0, 64'd13, 64'd10);
    drain("intt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
